instruction_fetch: RTL and testbench

//  Initiator side of the instruction-memory interface: owns the program counter, drives

---
 rtl/instr_pkg.sv | 18 +
 rtl/instruction_fetch.sv | 125 ++++++++++++
 tb/tb_instruction_fetch.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// Shared definitions for the instruction fetch stage: word geometry, the opcode field,
// the default halt opcode and the fetch state encoding.
package instr_pkg;

    localparam int WORD_W     = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;

    localparam logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE = 5'b00110;

    typedef enum logic [1:0] {
        FS_WAIT   = 2'd0,
        FS_RUN    = 2'd1,
        FS_HALTED = 2'd2,
        FS_FAULT  = 2'd3
    } fetch_state_t;

endpackage : instr_pkg

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads a combinational word-addressed memory and holds one
// word for decode behind a valid/ready handshake. Define FETCH_HALT_DETECT_EN to stop on HALT_OPCODE.
module instruction_fetch
    import instr_pkg::*;
#(
    parameter int unsigned              MEM_DEPTH   = 31,
    parameter int unsigned              START_WAIT  = 1,
    parameter logic [WORD_W-1:0]        RESET_PC    = '0,
    parameter logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE = instr_pkg::HALT_OPCODE
) (
    input  logic              clock,
    input  logic              reset,
    output logic [WORD_W-1:0] instruction_address,
    input  logic [WORD_W-1:0] instruction_data_input,
    input  logic              decode_ready,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_target,
    output logic              instruction_valid,
    output logic [WORD_W-1:0] instruction_register,
    output logic [WORD_W-1:0] instruction_pc,
    output logic              fetch_halted,
    output logic              fetch_fault
);

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(MEM_DEPTH);
    localparam logic [WORD_W-1:0] WAIT_W  = WORD_W'(START_WAIT);

    fetch_state_t      state, state_next;
    logic [WORD_W-1:0] pc, pc_next;
    logic [WORD_W-1:0] wait_count, wait_next;
    logic              valid_next;
    logic              capture;
    logic              transfer;
    logic              load_ok;
    logic              halt_hit;

    assign instruction_address = pc;
    assign transfer = instruction_valid & decode_ready;
    assign load_ok  = !instruction_valid | decode_ready;
    assign halt_hit = HALT_EN &&
                      (instruction_data_input[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned
    // and no latch can be inferred.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        wait_next  = wait_count;
        valid_next = instruction_valid;
        capture    = 1'b0;
        unique case (state)
            FS_WAIT: begin
                if (transfer) valid_next = 1'b0;
                wait_next = wait_count + 1'b1;
                if ((wait_count + 1'b1) >= WAIT_W) state_next = FS_RUN;
            end
            FS_RUN: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    valid_next = 1'b0;
                end else if (load_ok) begin
                    if (pc >= DEPTH_W) begin
                        valid_next = 1'b0;
                        state_next = FS_FAULT;
                    end else begin
                        capture    = 1'b1;
                        valid_next = 1'b1;
                        pc_next    = pc + 1'b1;
                        if (halt_hit) state_next = FS_HALTED;
                    end
                end
            end
            FS_HALTED: begin
                // A redirect both flushes the held word and restarts fetching.
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    valid_next = 1'b0;
                    state_next = FS_RUN;
                end else if (transfer) begin
                    valid_next = 1'b0;
                end
            end
            FS_FAULT: begin
                if (transfer) valid_next = 1'b0;
            end
            default: state_next = FS_FAULT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                <= FS_WAIT;
            pc                   <= RESET_PC;
            wait_count           <= '0;
            instruction_valid    <= 1'b0;
            instruction_register <= '0;
            instruction_pc       <= '0;
        end else begin
            state             <= state_next;
            pc                <= pc_next;
            wait_count        <= wait_next;
            instruction_valid <= valid_next;
            if (capture) begin
                instruction_register <= instruction_data_input;
                instruction_pc       <= pc;
            end
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    assign fetch_halted = (state == FS_HALTED);
`else
    assign fetch_halted = 1'b0;
`endif
    assign fetch_fault = (state == FS_FAULT);

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized run,
// all compared against a behavioural model of the fetch rules.
module tb_instruction_fetch;

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    localparam int DEPTH = 31;
    localparam int M_WAIT = 0, M_RUN = 1, M_HALTED = 2, M_FAULT = 3;

    logic        clock, reset;
    logic [31:0] instruction_address, instruction_data_input;
    logic        decode_ready, redirect_valid;
    logic [31:0] redirect_target;
    logic        instruction_valid;
    logic [31:0] instruction_register, instruction_pc;
    logic        fetch_halted, fetch_fault;

    logic [31:0] mem [64];

    int errors = 0;
    int checks = 0;

    // model state
    int          m_mode;
    int          m_wait;
    logic [31:0] m_pc, m_ir, m_ipc;
    logic        m_valid;

    instruction_fetch dut (
        .clock                  (clock),
        .reset                  (reset),
        .instruction_address    (instruction_address),
        .instruction_data_input (instruction_data_input),
        .decode_ready           (decode_ready),
        .redirect_valid         (redirect_valid),
        .redirect_target        (redirect_target),
        .instruction_valid      (instruction_valid),
        .instruction_register   (instruction_register),
        .instruction_pc         (instruction_pc),
        .fetch_halted           (fetch_halted),
        .fetch_fault            (fetch_fault)
    );

    assign instruction_data_input = (instruction_address < 32'd64) ?
                                    mem[instruction_address[5:0]] : 32'h0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_WAIT; m_wait = 0; m_pc = 0; m_ir = 0; m_ipc = 0; m_valid = 1'b0;
    endtask

    // One clock edge of the fetch rules, applied to the model.
    task automatic model_edge(input logic rdy, input logic rv, input logic [31:0] rt);
        logic xfer;
        xfer = m_valid && rdy;
        if (m_mode == M_WAIT) begin
            if (xfer) m_valid = 1'b0;
            m_wait++;
            if (m_wait >= 1) m_mode = M_RUN;
        end else if (m_mode == M_FAULT) begin
            if (xfer) m_valid = 1'b0;
        end else if (rv) begin
            m_pc = rt; m_valid = 1'b0; m_mode = M_RUN;
        end else if (m_mode == M_HALTED) begin
            if (xfer) m_valid = 1'b0;
        end else if (!m_valid || rdy) begin
            if (m_pc >= DEPTH) begin
                m_valid = 1'b0; m_mode = M_FAULT;
            end else begin
                m_ir = mem[m_pc]; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 1;
                if (HALT_EN && m_ir[31:27] == 5'b00110) m_mode = M_HALTED;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},   instruction_address, m_pc);
        check({tag, ".valid"},  {31'd0, instruction_valid}, {31'd0, m_valid});
        check({tag, ".ir"},     instruction_register, m_ir);
        check({tag, ".ipc"},    instruction_pc, m_ipc);
        check({tag, ".halted"}, {31'd0, fetch_halted}, {31'd0, m_mode == M_HALTED});
        check({tag, ".fault"},  {31'd0, fetch_fault},  {31'd0, m_mode == M_FAULT});
    endtask

    // Called at a falling edge: drive, take one rising edge, check at the next falling edge.
    task automatic step(input string tag, input logic rdy, input logic rv, input logic [31:0] rt);
        decode_ready = rdy; redirect_valid = rv; redirect_target = rt;
        @(posedge clock);
        model_edge(rdy, rv, rt);
        @(negedge clock);
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        decode_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check_all("reset");
    endtask

    task automatic fill_linear();
        for (int i = 0; i < 64; i++) mem[i] = 32'(i * 3);
    endtask

    initial begin
        reset = 1'b1;
        decode_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 0;
        fill_linear();
        model_reset();

        // 1: reset, wait cycle, then one word per cycle
        do_reset();
        check("t1.addr_wait", instruction_address, 32'd0);
        step("t1.wait", 1'b1, 1'b0, 0);
        check("t1.no_valid_yet", {31'd0, instruction_valid}, 32'd0);
        step("t1.w0", 1'b1, 1'b0, 0);
        check("t1.first_ir", instruction_register, 32'd0);
        check("t1.first_valid", {31'd0, instruction_valid}, 32'd1);
        step("t1.w1", 1'b1, 1'b0, 0);
        check("t1.ir3", instruction_register, 32'd3);
        step("t1.w2", 1'b1, 1'b0, 0);
        check("t1.ir6", instruction_register, 32'd6);

        // 2: stall on mem[2]
        for (int i = 0; i < 3; i++) step("t2.stall", 1'b0, 1'b0, 0);
        check("t2.hold_ir", instruction_register, 32'd6);
        check("t2.hold_pc", instruction_pc, 32'd2);
        check("t2.hold_addr", instruction_address, 32'd3);
        step("t2.release", 1'b1, 1'b0, 0);
        check("t2.next_pc", instruction_pc, 32'd3);
        check("t2.next_ir", instruction_register, 32'd9);

        // 3: redirect while stalled
        step("t3.stall", 1'b0, 1'b0, 0);
        step("t3.redir", 1'b0, 1'b1, 32'd10);
        check("t3.flushed", {31'd0, instruction_valid}, 32'd0);
        check("t3.addr10", instruction_address, 32'd10);
        step("t3.after", 1'b1, 1'b0, 0);
        check("t3.ir", instruction_register, 32'd30);
        check("t3.ipc", instruction_pc, 32'd10);

        // 4: halt opcode at word 5 (ordinary word when halt detection is off)
        mem[5] = 32'h3000_0000;
        step("t4.redir3", 1'b1, 1'b1, 32'd3);
        for (int i = 0; i < 3; i++) step("t4.run", 1'b1, 1'b0, 0);
        check("t4.ir5", instruction_register, 32'h3000_0000);
        step("t4.xfer", 1'b1, 1'b0, 0);
        step("t4.idle", 1'b1, 1'b0, 0);
`ifdef FETCH_HALT_DETECT_EN
        check("t4.halted", {31'd0, fetch_halted}, 32'd1);
        check("t4.valid0", {31'd0, instruction_valid}, 32'd0);
        check("t4.addr6", instruction_address, 32'd6);
`endif
        step("t4.resume", 1'b1, 1'b1, 32'd0);
        check("t4.resume_addr", instruction_address, 32'd0);
        step("t4.run0", 1'b1, 1'b0, 0);
        check("t4.ir0", instruction_register, 32'd0);

        // randomized run
        do_reset();
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? {5'b00110, 27'($urandom)} : $urandom;
        for (int i = 0; i < 400; i++)
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 32'($urandom_range(0, DEPTH - 1)));

        // 5: run off the end of memory
        fill_linear();
        do_reset();
        step("t5.wait", 1'b1, 1'b0, 0);
        step("t5.redir", 1'b1, 1'b1, 32'd27);
        for (int i = 0; i < 4; i++) step("t5.run", 1'b1, 1'b0, 0);
        check("t5.last_ipc", instruction_pc, 32'd30);
        check("t5.last_valid", {31'd0, instruction_valid}, 32'd1);
        step("t5.fault", 1'b1, 1'b0, 0);
        check("t5.fault", {31'd0, fetch_fault}, 32'd1);
        check("t5.valid0", {31'd0, instruction_valid}, 32'd0);
        step("t5.redir_ignored", 1'b1, 1'b1, 32'd0);
        check("t5.addr_stuck", instruction_address, 32'd31);
        step("t5.sticky", 1'b1, 1'b0, 0);

        // 6: async reset in the middle of a stall, redirect ignored in WAIT
        do_reset();
        for (int i = 0; i < 3; i++) step("t6.run", 1'b1, 1'b0, 0);
        step("t6.stall", 1'b0, 1'b0, 0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("t6.async");
        check("t6.valid0", {31'd0, instruction_valid}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        check_all("t6.released");
        step("t6.wait_redir", 1'b1, 1'b1, 32'd20);
        check("t6.addr_still0", instruction_address, 32'd0);
        for (int i = 0; i < 4; i++) step("t6.restart", 1'b1, 1'b0, 0);
        check("t6.ir9", instruction_register, 32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_instruction_fetch
